load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port: accepts one load or store at a time from the execute stage over a valid/ready handshake and drives the cache-backed data memory's WE/A/dataType/WD/RD interface. Sequences each access through a small FSM, absorbs the cache-miss penalty by stalling and retrying, sign- or zero-extends loaded bytes and halfwords, and returns one registered response per request. Sits between the execute stage and the data memory; the pipeline stalls while req_ready is low.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- MISS_PENALTY, 4, idle cycles inserted after a read miss before retry (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 word, 01 byte, 10 halfword (11 illegal)
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  DATA_WIDTH  store data, item in low bits
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or illegal-size request; no memory access made
- mem_we  out  2  00 idle, 01 read, 10 write
- mem_a  out  ADDR_WIDTH  memory address
- mem_dtype  out  2  same encoding as req_size
- mem_wd  out  DATA_WIDTH  write data
- mem_rd  in  DATA_WIDTH  read data; addressed item zero-extended in low bits, valid same cycle as mem_we=01
- mem_miss  in  1  1 = current read missed the cache; memory refills on that edge

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1, mem_we=00. On req_valid: latch all req_* fields. If illegal -> RESP with resp_err=1; else -> ACCESS.
- Illegal: size 11; halfword with addr[0]=1; word with addr[1:0]≠00.
- ACCESS: mem_a/mem_dtype/mem_wd from latched fields; mem_we=10 for store, 01 for load.
  - Store -> RESP.
  - Load, mem_miss=0 -> capture extended mem_rd into resp_rdata, -> RESP.
  - Load, mem_miss=1 -> load counter with MISS_PENALTY-1, -> WAIT.
- WAIT: mem_we=00, counter decrements; at 0 -> ACCESS (retry; refilled line now hits). A second consecutive miss repeats WAIT (no retry limit).
- RESP: resp_valid=1 for exactly one cycle, -> IDLE.
- Extension: byte uses mem_rd[7:0], halfword mem_rd[15:0]; sign bit 7/15 when req_unsigned=0; word passes through.
- Only one outstanding request; req_* ignored outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=00, mem_a=0, mem_dtype=00, mem_wd=0, counter=0.
- All outputs registered or decoded from state only; no req_*-to-mem_* combinational path.
- Load hit / store: accepted edge N, ACCESS cycle N+1, resp_valid cycle N+2; next accept earliest edge N+3.
- Load miss: response at N+2+MISS_PENALTY+1 (ACCESS, MISS_PENALTY WAIT cycles, retry ACCESS, RESP).
- Error: resp_valid cycle N+1, no mem_we≠00 ever driven.
- rst asserted mid-operation: immediate return to reset values; in-flight request dropped, no response; a store already in ACCESS may or may not have committed.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misalignment detection and resp_err as above.
- Undefined: resp_err tied 0; misaligned accesses issued to memory unchanged (memory wraps bytes per its own rules); size 11 still treated as word.

## Structure
- lsu_pkg: state enum, MEM_IDLE/MEM_READ/MEM_WRITE (2'b00/01/10), SIZE_WORD/SIZE_BYTE/SIZE_HALF (2'b00/01/10) constants.
- One sub-module: lsu_load_extend (combinational; mem_rd, size, unsigned -> extended word).

## Test plan
- Store word 0xDEADBEEF to 0x10010, then load word 0x10010 (hit) -> mem_we=10 then 01, resp_rdata=0xDEADBEEF, resp_valid at accept+2.
- Load byte signed from 0x10013 holding 0x80, mem_miss=1 on first ACCESS, MISS_PENALTY=4 -> four WAIT cycles with mem_we=00, retry, resp_rdata=0xFFFFFF80 at accept+7.
- Load halfword unsigned 0x8001 -> resp_rdata=0x00008001; signed -> 0xFFFF8001.
- Load word from 0x10002 with LSU_MISALIGN_CHECK_EN -> resp_err=1, resp_rdata=0, resp_valid at accept+1, mem_we stays 00.
- rst pulse during WAIT -> all outputs to reset values, no resp_valid; following request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and encodings for the load/store unit
//
// Purpose: FSM state type, memory-command and access-size encodings, and the
// alignment helper used when LSU_MISALIGN_CHECK_EN is defined.
// Ports: none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

  // Reserved size encoding, or an item that does not sit on its natural boundary.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11)                           bad = 1'b1;
    if (size == SIZE_HALF && addr_lo[0])         bad = 1'b1;
    if (size == SIZE_WORD && addr_lo != 2'b00)   bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of loaded bytes and halfwords
//
// Purpose: turn the memory's low-justified read item into a full data word.
// Ports:
//   mem_rd      read data from memory, item zero-extended in the low bits
//   size        access size (lsu_pkg SIZE_* encoding; 11 handled as word)
//   is_unsigned 1 = zero-extend, 0 = sign-extend
//   ext_data    extended result
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext_data
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~is_unsigned & mem_rd[7];
  assign sign_h = ~is_unsigned & mem_rd[15];

  always_comb begin
    ext_data = mem_rd;
    case (size)
      SIZE_BYTE: ext_data = {{(DATA_WIDTH-8){sign_b}}, mem_rd[7:0]};
      SIZE_HALF: ext_data = {{(DATA_WIDTH-16){sign_h}}, mem_rd[15:0]};
      default:   ext_data = mem_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for the data memory
//
// Purpose: accepts one load/store over req_valid/req_ready, issues it on the
// WE/A/dataType/WD/RD memory port, waits out cache-miss refills and retries,
// and returns one registered response.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned/illegal-size
// requests answered with resp_err and never sent to memory).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we/req_addr/req_size/req_unsigned/req_wdata   request fields
//   resp_valid/resp_rdata/resp_err                    one-cycle response
//   mem_we/mem_a/mem_dtype/mem_wd                     memory command
//   mem_rd/mem_miss                                   memory read data / miss flag
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MISS_PENALTY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [1:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [1:0]            mem_dtype,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic                  mem_miss
);

  localparam int CNT_W = $clog2(MISS_PENALTY + 1);

  lsu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic                  unsigned_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  illegal_req;
  logic [1:0]            size_in;
  logic                  accept;
  logic                  load_access;

`ifdef LSU_MISALIGN_CHECK_EN
  assign illegal_req = is_illegal(req_size, req_addr[1:0]);
  assign size_in     = req_size;
`else
  // Without checking, the reserved size goes out as a plain word access.
  assign illegal_req = 1'b0;
  assign size_in     = (req_size == 2'b11) ? SIZE_WORD : req_size;
`endif

  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign load_access = (state_q == ST_ACCESS) && !we_q;

  // Memory command comes only from latched fields, so no request input
  // reaches the memory port combinationally.
  assign mem_a     = addr_q;
  assign mem_dtype = size_q;
  assign mem_wd    = wdata_q;

  lsu_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .mem_rd      (mem_rd),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .ext_data    (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = MEM_IDLE;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal_req ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we = we_q ? MEM_WRITE : MEM_READ;
        if (!we_q && mem_miss) state_d = ST_WAIT;
        else                   state_d = ST_RESP;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SIZE_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we;
        unsigned_q <= req_unsigned;
        size_q     <= size_in;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= illegal_req;
      end
      if (load_access) begin
        // The refill happens on the miss edge; WAIT just idles the port for
        // MISS_PENALTY cycles (counter runs MISS_PENALTY-1 down to 0).
        if (mem_miss) cnt_q <= CNT_W'(MISS_PENALTY - 1);
        else          resp_rdata <= ext_data;
      end
      if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule
